// File: rtl/store_buffer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | store_buffer_pkg                                                 |
// | Shared constants, state encoding and entry layout for the        |
// | committed-store write buffer.                                    |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
package store_buffer_pkg;

  localparam int DATA_WIDTH   = 32;
  localparam int WB_SIZE      = 8;
  localparam int WB_TAG_WIDTH = 3;

  // Address bits that select the memory-mapped IO window (UART).
  localparam int         IO_ADDR_HI    = 17;
  localparam int         IO_ADDR_LO    = 16;
  localparam logic [1:0] IO_ADDR_MATCH = 2'b11;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WRITE = 2'd2
  } sb_state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [2:0]            nbytes;
  } sb_entry_t;

  // True when the address falls in the IO window.
  function automatic logic is_io_addr(input logic [DATA_WIDTH-1:0] addr);
    return addr[IO_ADDR_HI:IO_ADDR_LO] == IO_ADDR_MATCH;
  endfunction

endpackage
`default_nettype wire

// File: rtl/store_buffer_conflict.sv
`default_nettype none
// +------------------------------------------------------------------+
// | store_buffer_conflict                                            |
// | Word-granular overlap check between a pending load and every     |
// | valid store-buffer entry. Purely combinational.                  |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module store_buffer_conflict
  import store_buffer_pkg::*;
(
  input  logic [WB_SIZE-1:0]                   valid,
  input  logic [WB_SIZE-1:0][DATA_WIDTH-3:0]   entry_word,
  input  logic [DATA_WIDTH-3:0]                load_word,
  output logic                                 conflict
);

  logic [WB_SIZE-1:0] w_hit;

  for (genvar i = 0; i < WB_SIZE; i++) begin : g_cmp
    assign w_hit[i] = valid[i] && (entry_word[i] == load_word);
  end

  assign conflict = |w_hit;

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | store_buffer                                                     |
// | 8-slot circular buffer of committed stores drained one byte per  |
// | cycle through a shared, arbitrated RAM port. IO stores are       |
// | throttled against the UART transmit FIFO.                        |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module store_buffer
  import store_buffer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  in_rob_ce,
  input  logic [DATA_WIDTH-1:0] in_rob_addr,
  input  logic [DATA_WIDTH-1:0] in_rob_data,
  input  logic [2:0]            in_rob_size,
  output logic                  out_full,
  output logic                  out_empty,
  output logic                  out_mem_req,
  input  logic                  in_mem_gnt,
  output logic                  out_ram_wr,
  output logic [DATA_WIDTH-1:0] out_ram_addr,
  output logic [7:0]            out_ram_data,
  input  logic                  in_uart_full,
  input  logic [DATA_WIDTH-1:0] in_load_addr,
  output logic                  out_load_conflict
);

  sb_state_t               r_state;
  sb_state_t               w_state_nxt;
  logic [WB_TAG_WIDTH-1:0] r_head;
  logic [WB_TAG_WIDTH-1:0] r_tail;
  sb_entry_t               r_entries [WB_SIZE];
  logic [1:0]              r_byte_idx;
  logic                    r_wr;
  logic [DATA_WIDTH-1:0]   r_ram_addr;
  logic [7:0]              r_ram_data;
  logic [1:0]              r_wait_uart;

  sb_entry_t               w_head_entry;
  logic [WB_TAG_WIDTH-1:0] w_count;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_head_io;
  logic                    w_head_blocked;
  logic                    w_last_byte;
  logic [1:0]              w_next_idx;
  logic                    w_load_first;
  logic                    w_load_next;
  logic                    w_finish;

  logic [WB_SIZE-1:0]                 w_valid;
  logic [WB_SIZE-1:0][DATA_WIDTH-3:0] w_entry_word;
  logic                               w_unused_load_lsbs;

  assign w_head_entry = r_entries[r_head];
  assign w_count      = r_tail - r_head;
  // One slot stays empty so that full and empty are distinguishable.
  assign w_full       = (r_tail + WB_TAG_WIDTH'(1)) == r_head;
  assign w_empty      = (r_head == r_tail);
  assign w_push       = rdy & in_rob_ce & ~w_full;

  // IO heads wait for UART room and for the post-IO settle window.
  assign w_head_io      = is_io_addr(w_head_entry.addr);
  assign w_head_blocked = w_head_io & (in_uart_full | (r_wait_uart != 2'd0));

  assign w_last_byte = ({1'b0, r_byte_idx} == (w_head_entry.nbytes - 3'd1));
  assign w_next_idx  = r_byte_idx + 2'd1;

  // Entry i is live when it lies in [head, tail) modulo the ring size.
  for (genvar i = 0; i < WB_SIZE; i++) begin : g_entry
    logic [WB_TAG_WIDTH-1:0] w_offset;
    assign w_offset        = WB_TAG_WIDTH'(i) - r_head;
    assign w_valid[i]      = (w_offset < w_count);
    assign w_entry_word[i] = r_entries[i].addr[DATA_WIDTH-1:2];
  end

  // Byte offset within the word plays no part in word-overlap detection.
  assign w_unused_load_lsbs = ^in_load_addr[1:0];

  store_buffer_conflict u_conflict (
    .valid      (w_valid),
    .entry_word (w_entry_word),
    .load_word  (in_load_addr[DATA_WIDTH-1:2]),
    .conflict   (out_load_conflict)
  );

  // Drain FSM: next state plus the datapath strobes for each phase.
  always_comb begin
    w_state_nxt  = r_state;
    w_load_first = FALSE;
    w_load_next  = FALSE;
    w_finish     = FALSE;
    out_mem_req  = FALSE;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && !w_head_blocked) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        out_mem_req = TRUE;
        if (in_mem_gnt) begin
          w_load_first = TRUE;
          w_state_nxt  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        out_mem_req = TRUE;
        if (w_last_byte) begin
          w_finish    = TRUE;
          w_state_nxt = ST_IDLE;
        end else begin
          w_load_next = TRUE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register; frozen while rdy is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else if (rdy) begin
      r_state <= w_state_nxt;
    end
  end

  // Entry storage; contents outside [head, tail) are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_entries[r_tail] <= '{addr: in_rob_addr, data: in_rob_data, nbytes: in_rob_size};
    end
  end

  // Pointers, byte sequencer, RAM output registers and UART settle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_byte_idx  <= 2'd0;
      r_wr        <= FALSE;
      r_ram_addr  <= '0;
      r_ram_data  <= 8'd0;
      r_wait_uart <= 2'd0;
    end else if (rdy) begin
      if (w_push) begin
        r_tail <= r_tail + WB_TAG_WIDTH'(1);
      end
      if (r_wait_uart != 2'd0) begin
        r_wait_uart <= r_wait_uart - 2'd1;
      end
      if (w_load_first) begin
        r_ram_addr <= w_head_entry.addr;
        r_ram_data <= w_head_entry.data[7:0];
        r_wr       <= TRUE;
        r_byte_idx <= 2'd0;
      end
      if (w_load_next) begin
        r_ram_addr <= w_head_entry.addr + DATA_WIDTH'(w_next_idx);
        r_ram_data <= w_head_entry.data[{w_next_idx, 3'b000} +: 8];
        r_byte_idx <= w_next_idx;
      end
      if (w_finish) begin
        r_head <= r_head + WB_TAG_WIDTH'(1);
        r_wr   <= FALSE;
        if (w_head_io) begin
          r_wait_uart <= 2'd2;
        end
      end
    end
  end

  assign out_full     = w_full;
  assign out_empty    = w_empty;
  assign out_ram_wr   = r_wr & rdy;
  assign out_ram_addr = r_ram_addr;
  assign out_ram_data = r_ram_data;

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_store_buffer                                                  |
// | Self-checking bench: scoreboard of expected RAM bytes, a table   |
// | of load-overlap vectors and hand sequences for timing corners.   |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        in_rob_ce;
  logic [31:0] in_rob_addr;
  logic [31:0] in_rob_data;
  logic [2:0]  in_rob_size;
  logic        out_full;
  logic        out_empty;
  logic        out_mem_req;
  logic        in_mem_gnt;
  logic        out_ram_wr;
  logic [31:0] out_ram_addr;
  logic [7:0]  out_ram_data;
  logic        in_uart_full;
  logic [31:0] in_load_addr;
  logic        out_load_conflict;

  logic gnt_en;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_writes = 0;
  int last_wr_cyc = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  nbytes;
  } svec_t;

  typedef struct {
    logic [31:0] load_addr;
    logic        exp_conflict;
  } cvec_t;

  wr_t sb_q[$];

  store_buffer dut (
    .clk               (clk),
    .rst               (rst),
    .rdy               (rdy),
    .in_rob_ce         (in_rob_ce),
    .in_rob_addr       (in_rob_addr),
    .in_rob_data       (in_rob_data),
    .in_rob_size       (in_rob_size),
    .out_full          (out_full),
    .out_empty         (out_empty),
    .out_mem_req       (out_mem_req),
    .in_mem_gnt        (in_mem_gnt),
    .out_ram_wr        (out_ram_wr),
    .out_ram_addr      (out_ram_addr),
    .out_ram_data      (out_ram_data),
    .in_uart_full      (in_uart_full),
    .in_load_addr      (in_load_addr),
    .out_load_conflict (out_load_conflict)
  );

  always #5 clk = ~clk;

  // Arbiter model: grants whenever enabled and requested, held while requested.
  assign in_mem_gnt = gnt_en & out_mem_req;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every strobed byte must match the oldest expectation.
  always @(negedge clk) begin
    wr_t e;
    if (out_ram_wr === 1'b1) begin
      n_writes++;
      last_wr_cyc = cyc;
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                 out_ram_addr, out_ram_data);
      end else begin
        e = sb_q.pop_front();
        check("ram_addr", out_ram_addr, e.addr);
        check("ram_data", 32'(out_ram_data), 32'(e.data));
      end
    end
  end

  // Drive one push; expected bytes go to the scoreboard only if it should be accepted.
  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz,
                      input bit accept);
    wr_t e;
    @(posedge clk); #1;
    in_rob_ce   = 1'b1;
    in_rob_addr = a;
    in_rob_data = d;
    in_rob_size = sz;
    if (accept) begin
      for (int k = 0; k < int'(sz); k++) begin
        e.addr = a + 32'(k);
        e.data = d[8*k +: 8];
        sb_q.push_back(e);
      end
    end
    @(posedge clk); #1;
    in_rob_ce = 1'b0;
  endtask

  task automatic wait_writes(input int target, input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (n_writes >= target) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s: got %0d writes, expected %0d within %0d cycles", name, n_writes, target, budget);
    end
  endtask

  task automatic drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (sb_q.size() == 0 && out_empty === 1'b1 && out_mem_req === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  svec_t stores [5];
  cvec_t ctab   [7];

  initial begin
    int base;
    int c1;
    int c2;
    bit req_seen;

    stores[0] = '{32'h0000_1000, 32'h1122_3344, 3'd4};
    stores[1] = '{32'h0000_2003, 32'h0000_BEEF, 3'd2};
    stores[2] = '{32'h0000_3001, 32'h0000_0055, 3'd1};
    stores[3] = '{32'hFFFF_FFFE, 32'hCAFE_F00D, 3'd4};
    stores[4] = '{32'h0000_0007, 32'h0000_9988, 3'd2};

    ctab[0] = '{32'h0000_0206, 1'b1};
    ctab[1] = '{32'h0000_0208, 1'b0};
    ctab[2] = '{32'h0000_0204, 1'b1};
    ctab[3] = '{32'h0000_0207, 1'b1};
    ctab[4] = '{32'h0000_0203, 1'b0};
    ctab[5] = '{32'h0001_0204, 1'b0};
    ctab[6] = '{32'h8000_0204, 1'b0};

    rst = 1'b1; rdy = 1'b1; in_rob_ce = 1'b0; in_rob_addr = '0; in_rob_data = '0;
    in_rob_size = 3'd0; in_uart_full = 1'b0; in_load_addr = '0; gnt_en = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", 32'(out_mem_req), 32'd0);
    check("rst_ram_wr", 32'(out_ram_wr), 32'd0);
    check("rst_ram_addr", out_ram_addr, 32'd0);
    check("rst_ram_data", 32'(out_ram_data), 32'd0);
    check("rst_full", 32'(out_full), 32'd0);
    check("rst_empty", 32'(out_empty), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Size-4 store, granted immediately: four consecutive strobes then idle
    gnt_en = 1'b1;
    base = n_writes;
    push(32'h0000_0100, 32'hAABB_CCDD, 3'd4, 1'b1);
    wait_writes(base + 1, 20, "basic_first_byte");
    for (int j = 1; j < 4; j++) begin
      @(negedge clk); #1;
      check("basic_consecutive_wr", 32'(out_ram_wr), 32'd1);
    end
    @(negedge clk); #1;
    check("basic_req_low_after", 32'(out_mem_req), 32'd0);
    check("basic_wr_low_after", 32'(out_ram_wr), 32'd0);
    check("basic_empty_after", 32'(out_empty), 32'd1);

    // Mixed sizes, including an address that wraps past 0xFFFFFFFF
    for (int i = 0; i < 5; i++) begin
      push(stores[i].addr, stores[i].data, stores[i].nbytes, 1'b1);
    end
    drain("table_drain");

    // Fill to 7 entries without grant; 8th push dropped; full falls after one pop
    gnt_en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      push(32'h0000_0500 + 32'(4 * i), 32'(8'h10 + i), 3'd1, 1'b1);
    end
    @(negedge clk); #1;
    check("full_after_7", 32'(out_full), 32'd1);
    check("not_empty_after_7", 32'(out_empty), 32'd0);
    push(32'h0000_0600, 32'h0000_00EE, 3'd1, 1'b0);
    @(negedge clk); #1;
    check("full_after_drop", 32'(out_full), 32'd1);
    base = n_writes;
    gnt_en = 1'b1;
    wait_writes(base + 1, 20, "full_first_pop");
    check("full_during_pop", 32'(out_full), 32'd1);
    @(negedge clk); #1;
    check("full_falls_after_pop", 32'(out_full), 32'd0);
    drain("full_drain");

    // IO stores: held while UART full, then spaced by the settle window
    in_uart_full = 1'b1;
    base = n_writes;
    push(32'h0003_0000, 32'h0000_005A, 3'd1, 1'b1);
    push(32'h0003_0004, 32'h0000_00A5, 3'd1, 1'b1);
    req_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (out_mem_req === 1'b1) req_seen = 1'b1;
    end
    check("io_blocked_no_req", 32'(req_seen), 32'd0);
    @(posedge clk); #1;
    in_uart_full = 1'b0;
    wait_writes(base + 1, 20, "io_first_write");
    c1 = last_wr_cyc;
    wait_writes(base + 2, 20, "io_second_write");
    c2 = last_wr_cyc;
    check("io_gap_min", 32'(c2 - c1 >= 5), 32'd1);
    check("io_gap_bounded", 32'(c2 - c1 < 12), 32'd1);
    drain("io_drain");

    // Load-overlap vectors against a pending store at 0x204
    in_load_addr = 32'h0000_0206;
    @(negedge clk); #1;
    check("conflict_empty_fifo", 32'(out_load_conflict), 32'd0);
    gnt_en = 1'b0;
    push(32'h0000_0204, 32'h0102_0304, 3'd4, 1'b1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      in_load_addr = ctab[i].load_addr;
      #1;
      check($sformatf("conflict_vec%0d", i), 32'(out_load_conflict), 32'(ctab[i].exp_conflict));
    end
    in_load_addr = 32'h0000_0206;
    base = n_writes;
    @(posedge clk); #1;
    gnt_en = 1'b1;
    wait_writes(base + 1, 20, "conflict_first_byte");
    check("conflict_during_byte0", 32'(out_load_conflict), 32'd1);
    for (int j = 1; j < 4; j++) begin
      @(negedge clk); #1;
      check("conflict_during_write", 32'(out_load_conflict), 32'd1);
    end
    @(negedge clk); #1;
    check("conflict_clears", 32'(out_load_conflict), 32'd0);
    drain("conflict_drain");

    // rdy low for 3 cycles mid-write; a push during the gap is ignored
    base = n_writes;
    push(32'h0000_0400, 32'hDEAD_BEEF, 3'd4, 1'b1);
    wait_writes(base + 1, 20, "rdy_first_byte");
    @(posedge clk); #1;
    rdy = 1'b0;
    in_rob_ce = 1'b1;
    in_rob_addr = 32'h0000_0900;
    in_rob_data = 32'h0000_0077;
    in_rob_size = 3'd1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk); #1;
      check("rdy_gap_no_strobe", 32'(out_ram_wr), 32'd0);
    end
    @(posedge clk); #1;
    rdy = 1'b1;
    in_rob_ce = 1'b0;
    drain("rdy_drain");
    check("rdy_total_bytes", 32'(n_writes - base), 32'd4);

    // Reset during the third byte of a 4-byte store
    base = n_writes;
    push(32'h0000_0800, 32'h4433_2211, 3'd4, 1'b1);
    wait_writes(base + 2, 20, "rst_mid_second_byte");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    sb_q.delete();
    rst = 1'b0;
    in_load_addr = 32'h0000_0800;
    @(negedge clk); #1;
    check("midrst_mem_req", 32'(out_mem_req), 32'd0);
    check("midrst_ram_wr", 32'(out_ram_wr), 32'd0);
    check("midrst_ram_addr", out_ram_addr, 32'd0);
    check("midrst_ram_data", 32'(out_ram_data), 32'd0);
    check("midrst_full", 32'(out_full), 32'd0);
    check("midrst_empty", 32'(out_empty), 32'd1);
    check("midrst_conflict", 32'(out_load_conflict), 32'd0);
    repeat (6) @(negedge clk);
    check("sb_empty_end", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
